sha256_msg_loader: RTL and testbench
====================================

# sha256_msg_loader

Word-serial front end for the SHA-256 core. It collects sixteen 32-bit message words from the peripheral bus decode into a 512-bit block. On a start command it sequences the core's active-high reset, waits for the core's `ready`, and latches the 256-bit digest for word-wise readback. It sits between the bus-side register decode, upstream, and the `overall` SHA core, downstream.

## Interface
Parameters:
- `RST_CYCLES`, default 2 — cycles `core_reset` is held high after a start (range 1..15).
- `TIMEOUT`, default 1024 — RUN-state watchdog limit in cycles. Present only with `SHA_LOADER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  — sole clock, all logic on rising edge.
- `resetn`  in  1  — asynchronous, active-low reset.
- `wr_valid`  in  1  — message word write request.
- `wr_ready`  out  1  — write accepted when `wr_valid && wr_ready`.
- `wr_addr`  in  4  — word index 0..15.
- `wr_data`  in  32  — message word.
- `start`  in  1  — single-cycle start command.
- `clear`  in  1  — single-cycle abort and clear.
- `rd_addr`  in  3  — digest word select.
- `rd_data`  out  32  — selected digest word, combinational from the latched digest.
- `busy`  out  1  — high in RESET_CORE or RUN.
- `done`  out  1  — digest valid.
- `err`  out  1  — sticky error flag.
- `words_loaded`  out  16  — per-word loaded mask.
- `message`  out  512  — block to the core; word k occupies `[511-32k -: 32]`.
- `core_reset`  out  1  — active-high reset to the core.
- `core_ready`  in  1  — core completion flag.
- `core_hash`  in  256  — core digest.

## Operation
- FSM states: IDLE, RESET_CORE, RUN, DONE.
- **IDLE/DONE:**
  - `wr_ready`=1.
  - An accepted write stores `wr_data` into word `wr_addr` and sets mask bit `wr_addr`.
  - Rewriting a word overwrites it.
- **Start evaluation:** `start` in IDLE/DONE is evaluated against the mask *including* a same-cycle write.
  - Mask == 16'hFFFF: clear mask, clear `done`, clear `err`, go to RESET_CORE.
  - Otherwise: set `err` and stay in the current state.
- **RESET_CORE:**
  - `core_reset`=1 and `wr_ready`=0.
  - Counter runs RST_CYCLES cycles, then the FSM goes to RUN.
- **RUN:**
  - `core_reset`=0 and `wr_ready`=0.
  - `core_ready` is ignored in the first RUN cycle (this masks stale ready).
  - From the second RUN cycle, `core_ready`=1 latches `core_hash` and the FSM goes to DONE.
- **DONE:**
  - `done`=1.
  - `core_reset` stays 0 and the digest is held.
  - Writes do not disturb `done` or the digest; the next accepted start clears them.
- **`start` while busy:** ignored, no error.
- **`clear`:** highest priority in any state.
  - Next cycle: FSM in IDLE, `core_reset`=1, mask 0, `done` 0, `err` 0.
  - `message` and the digest are retained.
- **`rd_addr` mapping:** 0 → `hash[255:224]` … 7 → `hash[31:0]`.

## Timing
- **Reset values:**
  - FSM IDLE, `core_reset`=1, `busy`=0, `done`=0, `err`=0.
  - `words_loaded`=0, `message`=0, digest=0.
  - `rd_data`=0 and `wr_ready`=1.
- All status outputs are registered; only `wr_ready` and `rd_data` are combinational.
- Cycle-level sequence, with start accepted at edge 0:
  - `busy` and `core_reset` are 1 after edge 0.
  - `core_reset` falls after edge RST_CYCLES.
  - The first qualifying `core_ready` sample is at edge RST_CYCLES+2.
  - `core_ready` sampled at edge N gives `done`=1 and a valid digest after edge N, with `busy`=0 in the same cycle.
- A write is visible on `message` and `words_loaded` in the cycle after acceptance.
- `resetn` asserted mid-operation immediately forces the reset values, regardless of the clock.

## Configuration
- Macro `SHA_LOADER_TIMEOUT_EN`.
- **Defined:** a 32-bit RUN cycle counter is compiled in. Reaching TIMEOUT cycles in RUN sets `err`, drives `core_reset`=1 and returns the FSM to IDLE; `done` stays 0.
- **Undefined:** no counter exists, and RUN waits indefinitely for `core_ready`.

## Structure
- Package `sha256_loader_pkg` holds:
  - the FSM state enum;
  - `SHA_WORDS`=16 and `SHA_HASH_WORDS`=8;
  - the word width 32 and the full mask constant 16'hFFFF.
- Sub-module `sha256_word_buffer` holds the 16×32 register file plus the loaded mask, with write, mask-clear and full outputs.
- The FSM, reset sequencing, digest latch and read mux stay in the top module.

## Test plan
- **Reset:** assert `resetn`=0 mid-RUN → all outputs take their reset values asynchronously, with `core_reset`=1.
- **"abc" block:** write 0x61626380, fourteen words of 0, then 0x00000018, and start; the core model returns the digest → `done`=1.
  - `rd_addr` 0 reads 0xBA7816BF; `rd_addr` 7 reads 0xF20015AD.
  - `core_reset` is high exactly RST_CYCLES=2 cycles.
- **Incomplete block:** load words 0..14 only, then start → `err`=1, FSM stays IDLE, `busy`=0. Write word 15 together with start in the same cycle → accepted, `err` cleared.
- **Write while busy:** drive `wr_valid` while busy → `wr_ready`=0 and `message` is unchanged. The write completes at the first DONE cycle.
- **Stale ready:** hold `core_ready`=1 throughout → the digest latches no earlier than edge RST_CYCLES+2.
- **Clear and timeout:**
  - `clear` in RUN → next cycle IDLE, `core_reset`=1, `words_loaded`=0.
  - With `SHA_LOADER_TIMEOUT_EN`, TIMEOUT=16 and `core_ready` tied 0 → `err`=1 after 16 RUN cycles, with `done`=0.

Source files
------------

// File: rtl/sha256_loader_pkg.sv
// Shared types and constants for the SHA-256 message loader.
package sha256_loader_pkg;
    localparam int SHA_WORDS      = 16;
    localparam int SHA_HASH_WORDS = 8;
    localparam int WORD_W         = 32;
    localparam logic [SHA_WORDS-1:0] FULL_MASK = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET_CORE,
        S_RUN,
        S_DONE
    } state_t;
endpackage

// File: rtl/sha256_msg_loader_if.sv
// Bus-side port bundle of the loader: word writes, commands, digest readback, status.
interface sha256_msg_loader_if;
    import sha256_loader_pkg::*;

    // Write handshake: a word transfers on any rising edge where wr_valid && wr_ready.
    // wr_ready does not depend on wr_valid; the master holds addr/data stable while waiting.
    logic                  wr_valid;
    logic                  wr_ready;
    logic [3:0]            wr_addr;
    logic [WORD_W-1:0]     wr_data;
    logic                  start;
    logic                  clear;
    logic [2:0]            rd_addr;
    logic [WORD_W-1:0]     rd_data;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [SHA_WORDS-1:0]  words_loaded;

    modport master (
        output wr_valid, wr_addr, wr_data, start, clear, rd_addr,
        input  wr_ready, rd_data, busy, done, err, words_loaded
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, start, clear, rd_addr,
        output wr_ready, rd_data, busy, done, err, words_loaded
    );
endinterface

// File: rtl/sha256_word_buffer.sv
// 16x32 message block register with per-word loaded mask; o_full includes a same-cycle write.
module sha256_word_buffer
    import sha256_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          i_wr_en,
    input  logic [3:0]                    i_wr_addr,
    input  logic [WORD_W-1:0]             i_wr_data,
    input  logic                          i_mask_clr,
    output logic [SHA_WORDS*WORD_W-1:0]   o_message,
    output logic [SHA_WORDS-1:0]          o_mask,
    output logic                          o_full
);
    logic [SHA_WORDS*WORD_W-1:0] r_message;
    logic [SHA_WORDS-1:0]        r_mask;
    logic [SHA_WORDS-1:0]        w_wr_bit;
    logic [SHA_WORDS-1:0]        w_mask_next;

    always_comb begin
        w_wr_bit = '0;
        if (i_wr_en) w_wr_bit[i_wr_addr] = 1'b1;
    end

    assign w_mask_next = r_mask | w_wr_bit;
    assign o_full      = (w_mask_next == FULL_MASK);

    // Word 0 sits in the most significant slot of the block.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_message <= '0;
            r_mask    <= '0;
        end else begin
            if (i_wr_en) r_message[(SHA_WORDS-1-int'(i_wr_addr))*WORD_W +: WORD_W] <= i_wr_data;
            r_mask <= i_mask_clr ? '0 : w_mask_next;
        end
    end

    assign o_message = r_message;
    assign o_mask    = r_mask;
endmodule

// File: rtl/sha256_msg_loader.sv
// Loads a 512-bit block, sequences the SHA core reset and latches its digest.
// Optional RUN watchdog: define SHA_LOADER_TIMEOUT_EN.
module sha256_msg_loader
    import sha256_loader_pkg::*;
#(
    parameter int RST_CYCLES = 2
`ifdef SHA_LOADER_TIMEOUT_EN
    , parameter int TIMEOUT  = 1024
`endif
) (
    input  logic                        clk,
    input  logic                        resetn,
    sha256_msg_loader_if.slave          bus,
    output logic [SHA_WORDS*WORD_W-1:0] message,
    output logic                        core_reset,
    input  logic                        core_ready,
    input  logic [SHA_HASH_WORDS*WORD_W-1:0] core_hash,
    output state_t                      o_dbg_state
);
    localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

    state_t                          r_state;
    logic                            r_core_reset;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_err;
    logic                            r_run_first;
    logic [3:0]                      r_rst_cnt;
    logic [SHA_HASH_WORDS*WORD_W-1:0] r_digest;

    logic w_accept_en;
    logic w_wr_en;
    logic w_full;
    logic w_start_ok;
    logic w_mask_clr;
    logic w_timeout;

    assign w_accept_en = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_wr_en     = bus.wr_valid && w_accept_en;
    assign w_start_ok  = bus.start && w_accept_en && w_full;
    assign w_mask_clr  = bus.clear || w_start_ok;

    sha256_word_buffer u_buf (
        .clk        (clk),
        .resetn     (resetn),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (bus.wr_addr),
        .i_wr_data  (bus.wr_data),
        .i_mask_clr (w_mask_clr),
        .o_message  (message),
        .o_mask     (bus.words_loaded),
        .o_full     (w_full)
    );

`ifdef SHA_LOADER_TIMEOUT_EN
    logic [31:0] r_run_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_run_cnt <= '0;
        else if (r_state != S_RUN || bus.clear) r_run_cnt <= '0;
        else r_run_cnt <= r_run_cnt + 32'd1;
    end

    assign w_timeout = (r_state == S_RUN) && (r_run_cnt == 32'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_run_first  <= 1'b0;
            r_rst_cnt    <= '0;
            r_digest     <= '0;
        end else if (bus.clear) begin
            r_state      <= S_IDLE;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        if (w_full) begin
                            r_state      <= S_RESET_CORE;
                            r_core_reset <= 1'b1;
                            r_busy       <= 1'b1;
                            r_done       <= 1'b0;
                            r_err        <= 1'b0;
                            r_rst_cnt    <= '0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RESET_CORE: begin
                    if (r_rst_cnt == RST_LAST) begin
                        r_state      <= S_RUN;
                        r_core_reset <= 1'b0;
                        r_run_first  <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 4'd1;
                    end
                end
                S_RUN: begin
                    r_run_first <= 1'b0;
                    // A ready left over from the previous block is ignored in the first RUN cycle.
                    if (!r_run_first && core_ready) begin
                        r_digest <= core_hash;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (w_timeout) begin
                        r_err        <= 1'b1;
                        r_core_reset <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wr_ready = w_accept_en;
    assign bus.rd_data  = r_digest[(SHA_HASH_WORDS-1-int'(bus.rd_addr))*WORD_W +: WORD_W];
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign core_reset   = r_core_reset;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_sha256_msg_loader.sv
// Scoreboard bench for sha256_msg_loader: directed blocks, core model, readback checks.
module tb_sha256_msg_loader;
    import sha256_loader_pkg::*;

    logic         clk;
    logic         resetn;
    logic [511:0] message;
    logic         core_reset;
    logic         core_ready;
    logic [255:0] core_hash;
    state_t       dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] wexp_q[$];
    logic        rd_req;

    localparam logic [255:0] ABC_HASH =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] H2 =
        256'h01234567_89abcdef_deadbeef_cafef00d_13579bdf_2468ace0_0f0f0f0f_f0f0f0f0;
    logic [31:0] abc_words [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                   32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

    sha256_msg_loader_if bus_if ();

    sha256_msg_loader #(
        .RST_CYCLES (2)
`ifdef SHA_LOADER_TIMEOUT_EN
        , .TIMEOUT  (16)
`endif
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus_if),
        .message     (message),
        .core_reset  (core_reset),
        .core_ready  (core_ready),
        .core_hash   (core_hash),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] msg_word(input int k);
        return message[(15-k)*32 +: 32];
    endfunction

    // read monitor: compare digest word against the expected queue
    always @(posedge clk) begin
        if (rd_req) begin
            if (exp_q.size() == 0) chk("rd_queue_empty", 1'b1, 1'b0);
            else chk("rd_data", bus_if.rd_data, exp_q.pop_front());
        end
    end

    // write monitor: an accepted word must appear in the block one cycle later
    always @(posedge clk) begin
        logic [3:0] a;
        if (resetn && bus_if.wr_valid && bus_if.wr_ready) begin
            a = bus_if.wr_addr;
            @(negedge clk);
            if (wexp_q.size() == 0) chk("wr_queue_empty", 1'b1, 1'b0);
            else chk("message_word", msg_word(int'(a)), wexp_q.pop_front());
        end
    end

    // driver tasks
    task automatic write_word(input int addr, input logic [31:0] data);
        @(negedge clk);
        bus_if.wr_valid = 1'b1;
        bus_if.wr_addr  = 4'(addr);
        bus_if.wr_data  = data;
        wexp_q.push_back(data);
        @(negedge clk);
        bus_if.wr_valid = 1'b0;
    endtask

    task automatic load_block(input logic [31:0] base);
        for (int i = 0; i < 16; i++) write_word(i, base + 32'(i));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    task automatic read_word(input int addr, input logic [31:0] exp);
        @(negedge clk);
        bus_if.rd_addr = 3'(addr);
        exp_q.push_back(exp);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic wait_state(input state_t s, input string name);
        int n;
        n = 0;
        while (dbg_state != s && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, dbg_state, s);
    endtask

    initial begin
        int edges;
        int rst_cnt;
        int lat;
        int run_cyc;

        resetn = 1'b0;
        bus_if.wr_valid = 1'b0;
        bus_if.wr_addr  = '0;
        bus_if.wr_data  = '0;
        bus_if.start    = 1'b0;
        bus_if.clear    = 1'b0;
        bus_if.rd_addr  = '0;
        rd_req          = 1'b0;
        core_ready      = 1'b0;
        core_hash       = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        chk("rst_core_reset", core_reset, 1'b1);
        chk("rst_busy", bus_if.busy, 1'b0);
        chk("rst_done", bus_if.done, 1'b0);
        chk("rst_err", bus_if.err, 1'b0);
        chk("rst_words", bus_if.words_loaded, 16'h0000);
        chk("rst_message", message, 512'h0);
        chk("rst_rd_data", bus_if.rd_data, 32'h0);
        chk("rst_wr_ready", bus_if.wr_ready, 1'b1);
        chk("rst_state", dbg_state, S_IDLE);

        // incomplete block: words 0..14 of "abc"
        write_word(0, 32'h61626380);
        for (int i = 1; i < 15; i++) write_word(i, 32'h0);
        chk("partial_words", bus_if.words_loaded, 16'h7fff);
        pulse_start();
        chk("partial_err", bus_if.err, 1'b1);
        chk("partial_state", dbg_state, S_IDLE);
        chk("partial_busy", bus_if.busy, 1'b0);

        // word 15 written in the same cycle as start
        @(negedge clk);
        bus_if.wr_valid = 1'b1;
        bus_if.wr_addr  = 4'd15;
        bus_if.wr_data  = 32'h00000018;
        wexp_q.push_back(32'h00000018);
        bus_if.start    = 1'b1;
        @(negedge clk);
        bus_if.wr_valid = 1'b0;
        bus_if.start    = 1'b0;
        chk("start_err_clr", bus_if.err, 1'b0);
        chk("start_busy", bus_if.busy, 1'b1);
        chk("start_core_reset", core_reset, 1'b1);
        chk("start_words_clr", bus_if.words_loaded, 16'h0000);
        chk("start_state", dbg_state, S_RESET_CORE);
        chk("busy_wr_ready", bus_if.wr_ready, 1'b0);

        // write held while busy; core model answers 3 cycles after its reset drops
        bus_if.wr_valid = 1'b1;
        bus_if.wr_addr  = 4'd3;
        bus_if.wr_data  = 32'hdeadbeef;
        wexp_q.push_back(32'hdeadbeef);
        rst_cnt = 1;
        lat = 0;
        edges = 0;
        while (!bus_if.wr_ready && edges < 100) begin
            @(negedge clk);
            edges++;
            if (bus_if.busy && core_reset) rst_cnt++;
            if (bus_if.busy) chk("busy_msg_hold", msg_word(3), 32'h0);
            if (bus_if.busy && !core_reset) begin
                lat++;
                if (lat == 3) begin
                    core_ready = 1'b1;
                    core_hash  = ABC_HASH;
                end
            end
        end
        chk("abc_done_edge", 32'(edges), 32'd5);
        chk("abc_reset_cycles", 32'(rst_cnt), 32'd2);
        chk("abc_done", bus_if.done, 1'b1);
        chk("abc_busy_low", bus_if.busy, 1'b0);
        chk("abc_core_reset_low", core_reset, 1'b0);
        @(negedge clk);
        bus_if.wr_valid = 1'b0;
        chk("done_after_write", bus_if.done, 1'b1);
        for (int i = 0; i < 8; i++) read_word(i, abc_words[i]);

        // stale ready: core_ready held high through the whole sequence
        core_ready = 1'b1;
        core_hash  = H2;
        load_block(32'ha5000000);
        @(negedge clk);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        chk("stale_done_clr", bus_if.done, 1'b0);
        edges = 0;
        while (!bus_if.done && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("stale_done_edge", 32'(edges), 32'd4);
        read_word(0, 32'h01234567);
        read_word(7, 32'hf0f0f0f0);

        // clear while in RUN
        core_ready = 1'b0;
        load_block(32'hb0000000);
        pulse_start();
        wait_state(S_RUN, "clr_reach_run");
        bus_if.clear = 1'b1;
        @(negedge clk);
        bus_if.clear = 1'b0;
        chk("clr_state", dbg_state, S_IDLE);
        chk("clr_core_reset", core_reset, 1'b1);
        chk("clr_words", bus_if.words_loaded, 16'h0000);
        chk("clr_busy", bus_if.busy, 1'b0);
        chk("clr_done", bus_if.done, 1'b0);
        chk("clr_msg_kept", msg_word(15), 32'hb000000f);
        read_word(0, 32'h01234567);

`ifdef SHA_LOADER_TIMEOUT_EN
        load_block(32'hd0000000);
        pulse_start();
        wait_state(S_RUN, "to_reach_run");
        run_cyc = 0;
        while (dbg_state == S_RUN && run_cyc < 100) begin
            run_cyc++;
            @(negedge clk);
        end
        chk("to_run_cycles", 32'(run_cyc), 32'd16);
        chk("to_err", bus_if.err, 1'b1);
        chk("to_done", bus_if.done, 1'b0);
        chk("to_core_reset", core_reset, 1'b1);
        chk("to_state", dbg_state, S_IDLE);
`else
        run_cyc = 0;
`endif

        // asynchronous reset in the middle of RUN
        load_block(32'hc0000000);
        pulse_start();
        wait_state(S_RUN, "ar_reach_run");
        bus_if.rd_addr = 3'd0;
        #2 resetn = 1'b0;
        #1;
        chk("ar_core_reset", core_reset, 1'b1);
        chk("ar_busy", bus_if.busy, 1'b0);
        chk("ar_done", bus_if.done, 1'b0);
        chk("ar_err", bus_if.err, 1'b0);
        chk("ar_words", bus_if.words_loaded, 16'h0000);
        chk("ar_message", message, 512'h0);
        chk("ar_rd_data", bus_if.rd_data, 32'h0);
        chk("ar_wr_ready", bus_if.wr_ready, 1'b1);
        chk("ar_state", dbg_state, S_IDLE);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        chk("rd_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("wr_queue_drained", 32'(wexp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
